// File: rtl/countdown_timer_3_bit_pkg.sv
// -----------------------------------------------------------------------------
// countdown_timer_3_bit_pkg
//   Shared definitions for the countdown timer slice.
//   - state_t : controller state encoding (2 bits).
//               ST_IDLE = 2'd0, ST_COUNT = 2'd1, ST_DONE = 2'd2.
//   - ST_W    : width of the state encoding.
// -----------------------------------------------------------------------------
package countdown_timer_3_bit_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : countdown_timer_3_bit_pkg

// File: rtl/countdown_timer_3_bit_decrementer.sv
// -----------------------------------------------------------------------------
// decrementer_3_bit
//   Combinational 3-bit decrement (value_m1 = value - 1), written as an
//   explicit ripple-borrow chain so it reads as the mirror image of the
//   3-bit incrementer.
//
//   Ports:
//     value     in   3   operand
//     value_m1  out  3   operand minus one (wraps 0 -> 7; callers avoid 0)
// -----------------------------------------------------------------------------
module decrementer_3_bit (
    input  logic [2:0] value,
    output logic [2:0] value_m1
);

    // Bit 0 always flips; a higher bit flips only when every lower bit is 0,
    // i.e. when a borrow ripples up to it.
    assign value_m1[0] = ~value[0];
    assign value_m1[1] = value[1] ~^ value[0];
    assign value_m1[2] = value[2] ^ (~value[1] & ~value[0]);

endmodule : decrementer_3_bit

// File: rtl/countdown_timer_3_bit.sv
// -----------------------------------------------------------------------------
// countdown_timer_3_bit
//   Loadable down-counter used to time multi-cycle waits (e.g. memory latency
//   stalls). A start request loads a cycle count; the timer then counts down
//   once per cycle, reports busy while counting and pulses done for one cycle
//   when the count reaches zero.
//
//   Handshake: start is a single-cycle request, honoured only in IDLE or DONE
//   (ignored while busy). There is no ready; the caller observes busy/done.
//   abort has priority over start (and over hold when present).
//
//   Parameters:
//     WIDTH        count width (3 uses the ripple decrementer sub-module)
//     AUTO_RELOAD  1 = on reaching zero, reload the last load value and
//                  keep counting
//
//   Ports:
//     clk          in   1      clock, rising edge
//     rst_n        in   1      asynchronous active-low reset
//     start        in   1      load request
//     load_value   in   WIDTH  number of cycles to wait
//     abort        in   1      cancel; back to IDLE without a done pulse
//     hold         in   1      (COUNTDOWN_HOLD_EN only) freeze while counting
//     count        out  WIDTH  remaining count (registered)
//     busy         out  1      high while counting (registered)
//     done         out  1      one-cycle completion pulse (registered)
//     dbg_state    out  2      current controller state, for observation
//
//   Build option:
//     COUNTDOWN_HOLD_EN  adds the hold input; without it hold is tied low.
// -----------------------------------------------------------------------------
module countdown_timer_3_bit
    import countdown_timer_3_bit_pkg::*;
#(
    parameter int WIDTH       = 3,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] load_value,
    input  logic             abort,
`ifdef COUNTDOWN_HOLD_EN
    input  logic             hold,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output state_t           dbg_state
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic [WIDTH-1:0] count_dec;
    logic             hold_w;

`ifdef COUNTDOWN_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    // Decrement path: ripple-borrow sub-module for the native 3-bit width,
    // plain subtract for any other width.
    generate
        if (WIDTH == 3) begin : g_dec3
            decrementer_3_bit u_dec (
                .value    (count),
                .value_m1 (count_dec)
            );
        end else begin : g_dec_inline
            assign count_dec = count - WIDTH'(1);
        end
    endgenerate

    // Next-state / next-count logic.
    always_comb begin
        state_d  = state_q;
        count_d  = count;
        reload_d = reload_q;

        if (abort) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // A zero load completes immediately: straight to DONE.
                        count_d  = load_value;
                        reload_d = load_value;
                        state_d  = (load_value != '0) ? ST_COUNT : ST_DONE;
                    end else if ((state_q == ST_DONE) && AUTO_RELOAD) begin
                        // A zero reload value parks in DONE, keeping done high.
                        if (reload_q != '0) begin
                            count_d = reload_q;
                            state_d = ST_COUNT;
                        end else begin
                            count_d = '0;
                            state_d = ST_DONE;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_COUNT: begin
                    if (!hold_w) begin
                        // Only decrement a non-zero count so it never wraps.
                        if (count != '0) begin
                            count_d = count_dec;
                            state_d = (count_dec == '0) ? ST_DONE : ST_COUNT;
                        end else begin
                            count_d = '0;
                            state_d = ST_DONE;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // State, count, reload and decoded status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count    <= '0;
            reload_q <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count    <= count_d;
            reload_q <= reload_d;
            busy     <= (state_d == ST_COUNT);
            done     <= (state_d == ST_DONE);
        end
    end

    assign dbg_state = state_q;

endmodule : countdown_timer_3_bit

// File: tb/tb_countdown_timer_3_bit.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer_3_bit
//   Self-checking bench for countdown_timer_3_bit. Expected {count,busy,done}
//   words are queued as stimulus is applied and popped one per clock as the
//   DUT produces them. A second instance runs with AUTO_RELOAD=1.
//   Build with COUNTDOWN_HOLD_EN defined to also exercise the hold input.
// -----------------------------------------------------------------------------
module tb_countdown_timer_3_bit;
    import countdown_timer_3_bit_pkg::*;

    localparam int WIDTH = 3;
    localparam int W     = WIDTH + 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic             start      = 1'b0;
    logic [WIDTH-1:0] load_value = '0;
    logic             abort      = 1'b0;
    logic             hold       = 1'b0;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    state_t           dbg_state;

    countdown_timer_3_bit #(.WIDTH(WIDTH), .AUTO_RELOAD(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .load_value (load_value),
        .abort      (abort),
`ifdef COUNTDOWN_HOLD_EN
        .hold       (hold),
`endif
        .count      (count),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // ---------------- auto-reload DUT ----------------
    logic             ar_start      = 1'b0;
    logic [WIDTH-1:0] ar_load_value = '0;
    logic             ar_abort      = 1'b0;
    logic             ar_hold       = 1'b0;
    logic [WIDTH-1:0] ar_count;
    logic             ar_busy;
    logic             ar_done;
    state_t           ar_dbg_state;

    countdown_timer_3_bit #(.WIDTH(WIDTH), .AUTO_RELOAD(1'b1)) dut_ar (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (ar_start),
        .load_value (ar_load_value),
        .abort      (ar_abort),
`ifdef COUNTDOWN_HOLD_EN
        .hold       (ar_hold),
`endif
        .count      (ar_count),
        .busy       (ar_busy),
        .done       (ar_done),
        .dbg_state  (ar_dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;
    logic [W-1:0] obs;
    logic [W-1:0] obs_ar;
    int           errors = 0;
    int           checks = 0;

    assign obs    = {count, busy, done};
    assign obs_ar = {ar_count, ar_busy, ar_done};

    function automatic logic [W-1:0] word(input int c, input bit b, input bit d);
        return {WIDTH'(c), b, d};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #3;
        checks++;
        if (obs !== word(0, 0, 0)) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=%b", obs, word(0, 0, 0));
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state got=%0d want=%0d", dbg_state, ST_IDLE);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== word(0, 0, 0)) begin
            errors++;
            $display("FAIL reset_idle got=%b want=%b", obs, word(0, 0, 0));
        end
    endtask

    task automatic test_reset_mid_count();
        start = 1'b1; load_value = 3'd7;
        exp_q.push_back(word(7, 1, 0));
        exp_q.push_back(word(6, 1, 0));
        exp_q.push_back(word(5, 1, 0));
        tick();
        start = 1'b0;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL rst_mid_run got=%b want=%b", obs, exp_v);
            end
            if (exp_q.size() > 0) tick();
        end
        // Asynchronous: outputs clear without waiting for a clock edge.
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== word(0, 0, 0)) begin
            errors++;
            $display("FAIL rst_mid_async got=%b want=%b", obs, word(0, 0, 0));
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL rst_mid_state got=%0d want=%0d", dbg_state, ST_IDLE);
        end
        tick();
        rst_n = 1'b1;
        exp_q.push_back(word(0, 0, 0));
        exp_q.push_back(word(0, 0, 0));
        tick();
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL rst_mid_no_done got=%b want=%b", obs, exp_v);
            end
            if (exp_q.size() > 0) tick();
        end
    endtask

    task automatic test_count3();
        int idx;
        start = 1'b1; load_value = 3'd3;
        exp_q.push_back(word(3, 1, 0));
        exp_q.push_back(word(2, 1, 0));
        exp_q.push_back(word(1, 1, 0));
        exp_q.push_back(word(0, 0, 1));
        exp_q.push_back(word(0, 0, 0));
        exp_q.push_back(word(0, 0, 0));
        tick();
        // A start request while counting must be ignored.
        start = 1'b1; load_value = 3'd6;
        idx = 0;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL count3 step=%0d got=%b want=%b", idx, obs, exp_v);
            end
            if (idx == 1) start = 1'b0;
            idx++;
            if (exp_q.size() > 0) tick();
        end
        start = 1'b0;
    endtask

    task automatic test_load_zero();
        start = 1'b1; load_value = 3'd0;
        exp_q.push_back(word(0, 0, 1));
        exp_q.push_back(word(0, 0, 0));
        tick();
        start = 1'b0;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL load_zero got=%b want=%b", obs, exp_v);
            end
            if (exp_q.size() > 0) tick();
        end
    endtask

    task automatic test_abort();
        int idx;
        start = 1'b1; load_value = 3'd7;
        for (int c = 7; c >= 4; c--) exp_q.push_back(word(c, 1, 0));
        exp_q.push_back(word(0, 0, 0));
        exp_q.push_back(word(0, 0, 0));
        exp_q.push_back(word(0, 0, 0));
        tick();
        start = 1'b0;
        idx = 0;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL abort step=%0d got=%b want=%b", idx, obs, exp_v);
            end
            if (idx == 3) abort = 1'b1;
            if (idx == 4) abort = 1'b0;
            idx++;
            if (exp_q.size() > 0) tick();
        end
        // start and abort together in IDLE: abort wins, timer stays idle.
        start = 1'b1; abort = 1'b1; load_value = 3'd5;
        exp_q.push_back(word(0, 0, 0));
        exp_q.push_back(word(0, 0, 0));
        tick();
        start = 1'b0; abort = 1'b0;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL start_abort got=%b want=%b", obs, exp_v);
            end
            if (exp_q.size() > 0) tick();
        end
    endtask

    task automatic test_back_to_back();
        int idx;
        start = 1'b1; load_value = 3'd1;
        exp_q.push_back(word(1, 1, 0));
        exp_q.push_back(word(0, 0, 1));
        exp_q.push_back(word(2, 1, 0));
        exp_q.push_back(word(1, 1, 0));
        exp_q.push_back(word(0, 0, 1));
        exp_q.push_back(word(0, 0, 0));
        tick();
        start = 1'b0;
        idx = 0;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL back_to_back step=%0d got=%b want=%b", idx, obs, exp_v);
            end
            // Restart during the done cycle.
            if (idx == 1) begin start = 1'b1; load_value = 3'd2; end
            if (idx == 2) start = 1'b0;
            idx++;
            if (exp_q.size() > 0) tick();
        end
    endtask

    task automatic test_random_latency();
        int n;
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 7);
            start = 1'b1; load_value = WIDTH'(n);
            for (int c = n; c >= 1; c--) exp_q.push_back(word(c, 1, 0));
            exp_q.push_back(word(0, 0, 1));
            exp_q.push_back(word(0, 0, 0));
            tick();
            start = 1'b0;
            while (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL latency n=%0d got=%b want=%b", n, obs, exp_v);
                end
                if (exp_q.size() > 0) tick();
            end
        end
    endtask

`ifdef COUNTDOWN_HOLD_EN
    task automatic test_hold();
        int idx;
        start = 1'b1; load_value = 3'd4;
        exp_q.push_back(word(4, 1, 0));
        exp_q.push_back(word(3, 1, 0));
        exp_q.push_back(word(2, 1, 0));
        exp_q.push_back(word(2, 1, 0));
        exp_q.push_back(word(2, 1, 0));
        exp_q.push_back(word(2, 1, 0));
        exp_q.push_back(word(1, 1, 0));
        exp_q.push_back(word(0, 0, 1));
        exp_q.push_back(word(0, 0, 0));
        tick();
        start = 1'b0;
        idx = 0;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL hold step=%0d got=%b want=%b", idx, obs, exp_v);
            end
            if (idx == 2) hold = 1'b1;
            if (idx == 5) hold = 1'b0;
            idx++;
            if (exp_q.size() > 0) tick();
        end
    endtask
`endif

    task automatic test_auto_reload();
        ar_start = 1'b1; ar_load_value = 3'd2;
        for (int p = 0; p < 3; p++) begin
            exp_q.push_back(word(2, 1, 0));
            exp_q.push_back(word(1, 1, 0));
            exp_q.push_back(word(0, 0, 1));
        end
        tick();
        ar_start = 1'b0;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_ar !== exp_v) begin
                errors++;
                $display("FAIL auto_reload got=%b want=%b", obs_ar, exp_v);
            end
            if (exp_q.size() > 0) tick();
        end
        // Abort in the done cycle: pulse completes, then idle, no reload.
        ar_abort = 1'b1;
        exp_q.push_back(word(0, 0, 0));
        exp_q.push_back(word(0, 0, 0));
        tick();
        ar_abort = 1'b0;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_ar !== exp_v) begin
                errors++;
                $display("FAIL auto_reload_abort got=%b want=%b", obs_ar, exp_v);
            end
            if (exp_q.size() > 0) tick();
        end
        // Zero load with auto-reload parks in DONE with done held high.
        ar_start = 1'b1; ar_load_value = 3'd0;
        exp_q.push_back(word(0, 0, 1));
        exp_q.push_back(word(0, 0, 1));
        exp_q.push_back(word(0, 0, 1));
        tick();
        ar_start = 1'b0;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_ar !== exp_v) begin
                errors++;
                $display("FAIL auto_reload_zero got=%b want=%b", obs_ar, exp_v);
            end
            if (exp_q.size() > 0) tick();
        end
        ar_abort = 1'b1;
        tick();
        ar_abort = 1'b0;
        checks++;
        if (obs_ar !== word(0, 0, 0)) begin
            errors++;
            $display("FAIL auto_reload_zero_abort got=%b want=%b", obs_ar, word(0, 0, 0));
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_count3();
        test_load_zero();
        test_abort();
        test_back_to_back();
        test_random_latency();
`ifdef COUNTDOWN_HOLD_EN
        test_hold();
`endif
        test_auto_reload();
        test_reset_mid_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_countdown_timer_3_bit
